// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-side definitions: constants and the next-PC select
// encoding also used by the CPU control unit.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one async read port and one
// synchronous write port used for program loading.
module instruction_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Program-load write; deliberately independent of reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, fault tracking and
// the instruction memory that feeds the single-cycle CPU.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    input  logic              jump_reg,
    input  logic [31:0]       reg_target,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic [31:0]       instruction,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              instr_valid,
    output logic              fetch_fault
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  sel;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic [31:0] rdata;
    logic        out_of_range;
    logic        jr_misaligned;

    instruction_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk     (clk),
        .we_i    (load_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q[ADDR_W+1:2]),
        .rdata_o (rdata)
    );

    assign pc_plus4     = pc_q + WORD_BYTES;
    assign out_of_range = |pc_q[31:ADDR_W+2];
    assign br_off       = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jr_misaligned = |reg_target[1:0];

    // Redirect priority: JR over J over branch over sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    // Next-PC mux driven by the select encoding.
    always_comb begin
        next_pc = pc_plus4;
        unique case (sel)
            SEL_JR:  next_pc = {reg_target[31:2], 2'b00};
            SEL_J:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
            SEL_BR:  next_pc = pc_plus4 + br_off;
            default: next_pc = pc_plus4;
        endcase
    end

    // Next state: a bubble cycle only turns fetch on; a real fetch
    // advances or redirects. Load and stall both freeze the PC.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        fault_d = fault_q | out_of_range;
        if (load_en) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (!valid_q) begin
            valid_d = 1'b1;
        end else begin
            pc_d = next_pc;
            if (sel == SEL_JR && jr_misaligned) begin
                fault_d = 1'b1;
            end
        end
    end

    // PC, valid and sticky fault registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign instruction = (valid_q && !out_of_range) ? rdata : NOP_WORD;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch,
// redirects, stall, faults, range and mid-run reset.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(
        .DEPTH    (256),
        .ADDR_W   (8),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .instruction  (instruction),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .fetch_fault  (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_target  = 26'h0;
        jump_reg     = 1'b0;
        reg_target   = 32'h0;
        load_en      = 1'b0;
        load_addr    = 8'h0;
        load_data    = 32'h0;
    endtask

    initial begin
        logic [31:0] prog [8];
        prog[0] = 32'h11; prog[1] = 32'h22;
        prog[2] = 32'h33; prog[3] = 32'h44;
        prog[4] = 32'h55; prog[5] = 32'h66;
        prog[6] = 32'h77; prog[7] = 32'h88;

        idle();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = prog[i];
            step();
        end
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("rst_instr", instruction, 32'h0);

        idle();
        rst_n = 1'b1;
        step();
        chk("seq0_pc", pc, 32'h0);
        chk("seq0_valid", {31'h0, instr_valid}, 32'h1);
        chk("seq0_instr", instruction, 32'h11);
        step();
        chk("seq1_pc", pc, 32'h4);
        chk("seq1_instr", instruction, 32'h22);
        step();
        chk("seq2_pc", pc, 32'h8);
        chk("seq2_instr", instruction, 32'h33);
        step();
        chk("seq3_pc", pc, 32'hC);
        chk("seq3_instr", instruction, 32'h44);

        reg_target = 32'h8;
        jump_reg   = 1'b1;
        step();
        idle();
        chk("jr8_pc", pc, 32'h8);
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFE;
        step();
        chk("br_back_pc", pc, 32'h4);
        chk("br_back_instr", instruction, 32'h22);
        idle();
        step();
        chk("seq_after_br", pc, 32'h8);
        branch_taken = 1'b1;
        branch_imm   = 16'h0003;
        step();
        chk("br_fwd_pc", pc, 32'h18);
        chk("br_fwd_instr", instruction, 32'h77);

        idle();
        jump_reg   = 1'b1;
        reg_target = 32'h10;
        step();
        chk("jr10_pc", pc, 32'h10);
        chk("pc_plus4", pc_plus4, 32'h14);
        jump        = 1'b1;
        jump_target = 26'h40;
        jump_reg    = 1'b1;
        reg_target  = 32'h80;
        step();
        chk("prio_jr_pc", pc, 32'h80);
        jump_reg = 1'b0;
        step();
        chk("jump_pc", pc, 32'h100);

        idle();
        jump_reg   = 1'b1;
        reg_target = 32'hC;
        step();
        idle();
        chk("pre_stall_pc", pc, 32'hC);
        chk("pre_stall_fault", {31'h0, fetch_fault}, 32'h0);
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 16'h0010;
        step();
        chk("stall1_pc", pc, 32'hC);
        chk("stall1_instr", instruction, 32'h44);
        step();
        chk("stall2_pc", pc, 32'hC);
        chk("stall2_instr", instruction, 32'h44);

        idle();
        jump_reg   = 1'b1;
        reg_target = 32'h6;
        step();
        idle();
        chk("jr_mis_pc", pc, 32'h4);
        chk("jr_mis_fault", {31'h0, fetch_fault}, 32'h1);
        for (int i = 0; i < 5; i++) step();
        chk("fault_sticky_pc", pc, 32'h18);
        chk("fault_sticky", {31'h0, fetch_fault}, 32'h1);

        jump_reg   = 1'b1;
        reg_target = 32'h3FC;
        step();
        idle();
        chk("edge_pc", pc, 32'h3FC);
        step();
        chk("oor_pc", pc, 32'h400);
        chk("oor_instr", instruction, 32'h0);
        step();
        chk("oor_adv_pc", pc, 32'h404);
        chk("oor_fault", {31'h0, fetch_fault}, 32'h1);

        jump_reg   = 1'b1;
        reg_target = 32'h14;
        step();
        idle();
        chk("mid_pc20", pc, 32'h14);
        chk("mid_instr20", instruction, 32'h66);
        rst_n     = 1'b0;
        load_en   = 1'b1;
        load_addr = 8'h0;
        load_data = 32'hABCD;
        step();
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mid_rst_fault", {31'h0, fetch_fault}, 32'h0);
        idle();
        rst_n = 1'b1;
        step();
        chk("mid_rel_valid", {31'h0, instr_valid}, 32'h1);
        chk("mid_rel_instr", instruction, 32'hABCD);
        step();
        chk("mid_rel_next", instruction, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
